// File: rtl/mem_access.sv
// LC-3 memory-access stage: sequences direct and indirect data-memory reads/writes
// for one request at a time and hands load results to Writeback.
module mem_access (
   input  logic        clock,
   input  logic        reset,
   input  logic        start,
   input  logic [1:0]  M_Control,
   input  logic [15:0] M_addr,
   input  logic [15:0] M_data,
   input  logic [15:0] Data_dout,
   output logic [15:0] Data_addr,
   output logic [15:0] Data_din,
   output logic        Data_en,
   output logic        Data_we,
   output logic [15:0] memout,
   output logic        wb_en,
   output logic        done,
   output logic        busy
);

   localparam logic [1:0] OP_LD  = 2'd0;
   localparam logic [1:0] OP_LDI = 2'd1;
   localparam logic [1:0] OP_ST  = 2'd2;
   localparam logic [1:0] OP_STI = 2'd3;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      RD_PTR   = 3'd1,
      CAP_PTR  = 3'd2,
      RD_DATA  = 3'd3,
      CAP_DATA = 3'd4,
      WR       = 3'd5,
      DONE     = 3'd6
   } state_t;

   state_t      state_reg;
   state_t      state_next;
   logic [1:0]  op_reg;
   logic [15:0] addr_reg;
   logic [15:0] data_reg;
   logic [15:0] memout_reg;

   // State register plus the operand/result registers that move with it.
   always_ff @(posedge clock) begin
      if (!reset) begin
         state_reg  <= IDLE;
         op_reg     <= 2'd0;
         addr_reg   <= 16'd0;
         data_reg   <= 16'd0;
         memout_reg <= 16'd0;
      end else begin
         state_reg <= state_next;
         if (state_reg == IDLE && start) begin
            op_reg   <= M_Control;
            addr_reg <= M_addr;
            data_reg <= M_data;
         end
         if (state_reg == CAP_PTR) begin
            addr_reg <= Data_dout;
         end
         if (state_reg == CAP_DATA) begin
            memout_reg <= Data_dout;
         end
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: begin
            if (start) begin
               case (M_Control)
                  OP_LD:   state_next = RD_DATA;
                  OP_LDI:  state_next = RD_PTR;
                  OP_ST:   state_next = WR;
                  OP_STI:  state_next = RD_PTR;
                  default: state_next = IDLE;
               endcase
            end
         end
         RD_PTR:   state_next = CAP_PTR;
         CAP_PTR:  state_next = (op_reg == OP_STI) ? WR : RD_DATA;
         RD_DATA:  state_next = CAP_DATA;
         CAP_DATA: state_next = DONE;
         WR:       state_next = DONE;
         DONE:     state_next = IDLE;
         default:  state_next = IDLE;
      endcase
   end

   // Memory-side outputs decode only from registered state and operands.
   always_comb begin
      Data_en   = 1'b0;
      Data_we   = 1'b0;
      Data_addr = 16'd0;
      Data_din  = 16'd0;
      done      = 1'b0;
      wb_en     = 1'b0;
      case (state_reg)
         RD_PTR, RD_DATA: begin
            Data_en   = 1'b1;
            Data_addr = addr_reg;
         end
         WR: begin
            Data_en   = 1'b1;
            Data_we   = 1'b1;
            Data_addr = addr_reg;
            Data_din  = data_reg;
         end
         DONE: begin
            done  = 1'b1;
            wb_en = (op_reg == OP_LD) || (op_reg == OP_LDI);
         end
         default: begin
         end
      endcase
   end

   assign memout = memout_reg;
   assign busy   = (state_reg != IDLE);

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: a per-cycle expected-trace model built from the
// operation rules, checked against the DUT every cycle, plus literal spot checks.
module tb_mem_access;

   logic        clock = 1'b0;
   logic        reset;
   logic        start;
   logic [1:0]  M_Control;
   logic [15:0] M_addr;
   logic [15:0] M_data;
   logic [15:0] Data_dout = 16'hA5A5;
   logic [15:0] Data_addr;
   logic [15:0] Data_din;
   logic        Data_en;
   logic        Data_we;
   logic [15:0] memout;
   logic        wb_en;
   logic        done;
   logic        busy;

   mem_access dut (
      .clock     (clock),
      .reset     (reset),
      .start     (start),
      .M_Control (M_Control),
      .M_addr    (M_addr),
      .M_data    (M_data),
      .Data_dout (Data_dout),
      .Data_addr (Data_addr),
      .Data_din  (Data_din),
      .Data_en   (Data_en),
      .Data_we   (Data_we),
      .memout    (memout),
      .wb_en     (wb_en),
      .done      (done),
      .busy      (busy)
   );

   always #5 clock = ~clock;

   typedef struct packed {
      logic        en;
      logic        we;
      logic [15:0] addr;
      logic [15:0] din;
      logic        done;
      logic        wb;
      logic        busy;
      logic [15:0] memout;
   } exp_t;

   logic [15:0] ram     [0:65535];
   logic [15:0] ref_mem [0:65535];
   int          write_count = 0;
   int          vectors = 0;
   int          miscompares = 0;
   int          cycle = 0;
   bit          checking = 0;
   exp_t        exp_q[$];
   logic [15:0] last_memout = 16'd0;
   logic [15:0] model_memout = 16'd0;

   // Synchronous RAM with one-cycle read latency; junk when no read was issued.
   always @(posedge clock) begin
      cycle <= cycle + 1;
      if (Data_en && Data_we) begin
         ram[Data_addr] <= Data_din;
         write_count    <= write_count + 1;
         Data_dout      <= 16'hA5A5;
      end else if (Data_en) begin
         Data_dout <= ram[Data_addr];
      end else begin
         Data_dout <= 16'hA5A5;
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      vectors++;
      if (act !== req) begin
         miscompares++;
         $display("FAIL %s (cycle %0d): got %h, required %h", name, cycle, act, req);
      end
   endtask

   function automatic exp_t mk(input logic en, input logic we, input logic [15:0] addr,
                               input logic [15:0] din, input logic dn, input logic wb,
                               input logic bsy, input logic [15:0] mo);
      exp_t e;
      e.en = en; e.we = we; e.addr = addr; e.din = din;
      e.done = dn; e.wb = wb; e.busy = bsy; e.memout = mo;
      return e;
   endfunction

   always @(negedge clock) begin : compare
      exp_t e;
      exp_t act;
      if (checking) begin
         if (exp_q.size() > 0) e = exp_q.pop_front();
         else                  e = mk(0, 0, 16'd0, 16'd0, 0, 0, 0, last_memout);
         last_memout = e.memout;
         act = {Data_en, Data_we, Data_addr, Data_din, done, wb_en, busy, memout};
         check("cycle_trace", 64'(act), 64'(e));
      end
   end

   // Push the expected trace for one request (cycle 0 = start cycle) and drive it.
   task automatic issue(input logic [1:0] op, input logic [15:0] a, input logic [15:0] d,
                        input bit spam);
      int          n;
      logic [15:0] p;
      exp_q.push_back(mk(0, 0, 16'd0, 16'd0, 0, 0, 0, model_memout));
      case (op)
         2'd0: begin
            exp_q.push_back(mk(1, 0, a, 16'd0, 0, 0, 1, model_memout));
            exp_q.push_back(mk(0, 0, 16'd0, 16'd0, 0, 0, 1, model_memout));
            model_memout = ref_mem[a];
            exp_q.push_back(mk(0, 0, 16'd0, 16'd0, 1, 1, 1, model_memout));
            n = 3;
         end
         2'd1: begin
            p = ref_mem[a];
            exp_q.push_back(mk(1, 0, a, 16'd0, 0, 0, 1, model_memout));
            exp_q.push_back(mk(0, 0, 16'd0, 16'd0, 0, 0, 1, model_memout));
            exp_q.push_back(mk(1, 0, p, 16'd0, 0, 0, 1, model_memout));
            exp_q.push_back(mk(0, 0, 16'd0, 16'd0, 0, 0, 1, model_memout));
            model_memout = ref_mem[p];
            exp_q.push_back(mk(0, 0, 16'd0, 16'd0, 1, 1, 1, model_memout));
            n = 5;
         end
         2'd2: begin
            exp_q.push_back(mk(1, 1, a, d, 0, 0, 1, model_memout));
            ref_mem[a] = d;
            exp_q.push_back(mk(0, 0, 16'd0, 16'd0, 1, 0, 1, model_memout));
            n = 2;
         end
         default: begin
            p = ref_mem[a];
            exp_q.push_back(mk(1, 0, a, 16'd0, 0, 0, 1, model_memout));
            exp_q.push_back(mk(0, 0, 16'd0, 16'd0, 0, 0, 1, model_memout));
            exp_q.push_back(mk(1, 1, p, d, 0, 0, 1, model_memout));
            ref_mem[p] = d;
            exp_q.push_back(mk(0, 0, 16'd0, 16'd0, 1, 0, 1, model_memout));
            n = 4;
         end
      endcase
      start = 1'b1; M_Control = op; M_addr = a; M_data = d;
      for (int k = 1; k <= n; k++) begin
         @(posedge clock); #1;
         if (spam) begin
            start = 1'b1; M_Control = ~op; M_addr = ~a; M_data = ~d;
         end else begin
            start = 1'b0; M_addr = 16'h7777; M_data = 16'h6666;
         end
      end
      @(posedge clock); #1;
      start = 1'b0;
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, required $finish");
      $fatal(1, "timeout");
   end

   initial begin : driver
      int wc;
      for (int i = 0; i < 65536; i++) begin
         ram[i] = 16'd0;
         ref_mem[i] = 16'd0;
      end
      ram[16'h3000] = 16'hBEEF; ref_mem[16'h3000] = 16'hBEEF;
      ram[16'h3001] = 16'h4000; ref_mem[16'h3001] = 16'h4000;
      ram[16'h4000] = 16'h8001; ref_mem[16'h4000] = 16'h8001;
      ram[16'h3002] = 16'hFFFF; ref_mem[16'h3002] = 16'hFFFF;
      ram[16'h3003] = 16'h0000; ref_mem[16'h3003] = 16'h0000;

      // Reset held two edges with start asserted: outputs must stay quiet.
      reset = 1'b0; start = 1'b1; M_Control = 2'd3; M_addr = 16'h3002; M_data = 16'h9999;
      @(posedge clock); #1;
      checking = 1;
      @(posedge clock); #1;
      reset = 1'b1; start = 1'b0;
      @(posedge clock); #1;
      check("reset_writes", 64'(write_count), 64'd0);

      issue(2'd0, 16'h3000, 16'h0000, 0);
      check("ld_memout", 64'(memout), 64'h BEEF);
      issue(2'd1, 16'h3001, 16'h0000, 0);
      check("ldi_memout", 64'(memout), 64'h8001);

      wc = write_count;
      issue(2'd3, 16'h3002, 16'h1234, 0);
      check("sti_ram_ffff", 64'(ram[16'hFFFF]), 64'h1234);
      check("sti_memout_held", 64'(memout), 64'h8001);
      check("sti_one_write", 64'(write_count - wc), 64'd1);

      wc = write_count;
      issue(2'd2, 16'h0000, 16'h5555, 1);
      check("st_ram_0", 64'(ram[16'h0000]), 64'h5555);
      check("st_one_write", 64'(write_count - wc), 64'd1);
      check("st_busy_after", 64'(busy), 64'd0);

      issue(2'd0, 16'hFFFF, 16'h0000, 0);
      check("ld_ffff_memout", 64'(memout), 64'h1234);
      issue(2'd1, 16'h3003, 16'h0000, 0);
      check("ldi_ptr0_memout", 64'(memout), 64'h5555);

      // Reset asserted during CAP_PTR of an LDI: aborted, memout cleared.
      exp_q.push_back(mk(0, 0, 16'd0, 16'd0, 0, 0, 0, model_memout));
      exp_q.push_back(mk(1, 0, 16'h3001, 16'd0, 0, 0, 1, model_memout));
      exp_q.push_back(mk(0, 0, 16'd0, 16'd0, 0, 0, 1, model_memout));
      exp_q.push_back(mk(0, 0, 16'd0, 16'd0, 0, 0, 0, 16'd0));
      model_memout = 16'd0;
      start = 1'b1; M_Control = 2'd1; M_addr = 16'h3001; M_data = 16'd0;
      @(posedge clock); #1;
      start = 1'b0;
      @(posedge clock); #1;
      reset = 1'b0;
      @(posedge clock); #1;
      reset = 1'b1;
      @(posedge clock); #1;
      check("abort_memout", 64'(memout), 64'd0);
      check("abort_busy", 64'(busy), 64'd0);

      issue(2'd0, 16'h3000, 16'h0000, 0);
      check("recover_memout", 64'(memout), 64'hBEEF);

      repeat (3) @(posedge clock);
      #1;
      check("trace_drained", 64'(exp_q.size()), 64'd0);
      checking = 0;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/mem_access.md
# mem_access

Memory-access stage of the LC-3 pipeline, sitting between Execute and Writeback. It accepts one load/store request at a time from Execute and sequences the data-memory reads and writes, including the two-access indirect forms (LDI/STI). For loads it returns the fetched word on `memout` together with a one-cycle `wb_en` pulse. Writeback consumes both, with its own `W_Control` set to select `memout`.

## Interface
- No parameters. Data width is fixed at 16 bits and the address width at 16 bits.
- `clock` in 1: single clock; all state changes on the rising edge.
- `reset` in 1: synchronous, active-low. It is sampled on the rising edge of `clock`.
- `start` in 1: request strobe from Execute. It is sampled only when in IDLE.
- `M_Control` in 2: operation select.
  - 0 = direct read (LD/LDR).
  - 1 = indirect read (LDI).
  - 2 = direct write (ST/STR).
  - 3 = indirect write (STI).
- `M_addr` in 16: effective address computed by Execute.
- `M_data` in 16: store data, used for ops 2 and 3.
- `Data_dout` in 16: read data from data memory, valid the cycle after a read is issued.
- `Data_addr` out 16: data-memory address.
- `Data_din` out 16: data-memory write data.
- `Data_en` out 1: data-memory access enable.
- `Data_we` out 1: data-memory write enable. It is meaningful only when `Data_en` = 1.
- `memout` out 16: registered load result to Writeback.
- `wb_en` out 1: one-cycle pulse when a load result is valid. It drives Writeback `enable_writeback`.
- `done` out 1: one-cycle completion pulse, issued for every operation.
- `busy` out 1: high whenever the state is not IDLE.

## Operation
- **States:** IDLE, RD_PTR, CAP_PTR, RD_DATA, CAP_DATA, WR, DONE. The state is a registered value; all memory-side outputs decode combinationally from the registered state and registered operands.
- **IDLE:**
  - On `start` = 1, latch `M_Control` into `op`, `M_addr` into `addr_q`, and `M_data` into `data_q`.
  - Next state is RD_PTR for op 1 or 3, RD_DATA for op 0, and WR for op 2.
- **RD_PTR:** `Data_en` = 1, `Data_we` = 0, `Data_addr` = `addr_q`. Next state is CAP_PTR.
- **CAP_PTR:** `addr_q` <= `Data_dout` (the pointer). Next state is RD_DATA for op 1 and WR for op 3.
- **RD_DATA:** `Data_en` = 1, `Data_we` = 0, `Data_addr` = `addr_q`. Next state is CAP_DATA.
- **CAP_DATA:** `memout` <= `Data_dout`. Next state is DONE.
- **WR:** `Data_en` = 1, `Data_we` = 1, `Data_addr` = `addr_q`, `Data_din` = `data_q`. Next state is DONE.
- **DONE:**
  - `done` = 1.
  - `wb_en` = 1 only if `op` is 0 or 1.
  - Next state is IDLE.
- **Outside active states:**
  - `Data_en`, `Data_we` and `Data_din` are 0 outside RD_*/WR; `Data_din` is 0 outside WR.
  - `Data_addr` is 0 in IDLE, CAP_*, and DONE.
- **Addresses:** pointers are used as full 16-bit addresses. No arithmetic is performed, so 16'hFFFF and 16'h0000 are legal and pass unmodified.
- **Stores:** `memout` is not modified by ops 2 or 3 and holds its last load value.

## Timing
- **Reset:** while `reset` = 0 at an edge, the next state is IDLE, `memout` = 0, and `op`, `addr_q`, `data_q` = 0. Consequently all outputs (`done`, `wb_en`, `busy`, `Data_en`, `Data_we`, `Data_addr`, `Data_din`) read 0.
- **Latency:** with `start` sampled at edge 0, `done` is high during the cycle after edge N:
  - op 0: N = 3.
  - op 1: N = 5.
  - op 2: N = 2.
  - op 3: N = 4.
- **Memory protocol:** the memory is synchronous, with one-cycle read latency. `Data_dout` is sampled exactly one edge after the RD_* cycle.
- **Back-to-back requests:**
  - `start` while `busy` = 1 (including during DONE) is ignored. No queuing takes place.
  - A new request is accepted no earlier than the first IDLE cycle after DONE, so the minimum issue interval is N+1 cycles.
- **Result validity:** `memout` is stable and valid throughout the DONE cycle and holds until the next CAP_DATA.
- **Reset mid-operation:** reset in any state aborts the operation. `Data_en` is 0 in the cycle following the reset edge, and no `done` or `wb_en` is produced for the aborted request. A write is therefore issued only if the WR cycle completed before reset.
- **Simultaneous reset and `start`:** reset wins and the request is dropped.
- **Operand stability:** `M_*` inputs are don't-care except at the accepting edge.

## Test plan
- **Reset:** hold `reset` = 0 for 2 cycles with `start` = 1 -> all outputs 0, `busy` = 0, no memory access.
- **LD:** mem[16'h3000] = 16'hBEEF; `start` with op 0, `M_addr` = 16'h3000 -> read at 16'h3000 in cycle 1; `done` = `wb_en` = 1 in cycle 3 with `memout` = 16'hBEEF.
- **LDI:** mem[16'h3001] = 16'h4000, mem[16'h4000] = 16'h8001; op 1, `M_addr` = 16'h3001 -> reads at 16'h3001 (cycle 1) and 16'h4000 (cycle 3); `memout` = 16'h8001 with `wb_en` in cycle 5.
- **STI with wrap-edge pointer:** mem[16'h3002] = 16'hFFFF; op 3, `M_data` = 16'h1234 -> write of 16'h1234 to 16'hFFFF in cycle 3; `done` in cycle 4, `wb_en` = 0, `memout` unchanged.
- **ST, then ignored start:** op 2 to 16'h0000 with data 16'h5555; pulse `start` again during WR/DONE -> exactly one write, `done` in cycle 2; the second request is ignored and `busy` = 0 in cycle 3.
- **Reset mid-LDI:** deassert `reset` (drive 0) in CAP_PTR -> IDLE the next cycle; no RD_DATA access, no `done`/`wb_en`, `memout` = 0.
